// File: rtl/vga_rect_info_tx.sv
// ---------------------------------------------------------------------------
// vga_rect_info_tx
//   Rasterises rectangle-fill commands into the 32-bit `info` pixel-write word
//   stream consumed by the VGA screen/VRAM block, one word per pixel in
//   row-major order. A frame-swap word (0x8000_0000) can optionally follow
//   the last pixel of a rectangle.
//
//   Word format: [31] swap, [7+2*SW:8+SW] {x,1'b0}, [7+SW:8] {y,1'b0},
//                [COLOR_W-1:0] colour, all other bits 0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake (ready only in IDLE)
//   cmd_x0, cmd_y0      top-left pixel
//   cmd_w, cmd_h        size in pixels (0 in either => no pixel words)
//   cmd_color           colour index
//   cmd_swap            append a swap word after the rectangle
//   info/info_valid     word stream to the screen block
//   info_ready          sink accept
//   busy                FSM not in IDLE
//
// Build option
//   VGA_RECT_CLIP_EN    when defined, pixels outside the drawable window
//                       x in [76,563], y in [100,379] are skipped (one cycle
//                       each, no word emitted). The swap word is unaffected.
// ---------------------------------------------------------------------------
module vga_rect_info_tx #(
    parameter int SCREEN_WIDTH = 10,
    parameter int COLOR_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [SCREEN_WIDTH-2:0] cmd_x0,
    input  logic [SCREEN_WIDTH-2:0] cmd_y0,
    input  logic [SCREEN_WIDTH-2:0] cmd_w,
    input  logic [SCREEN_WIDTH-2:0] cmd_h,
    input  logic [COLOR_W-1:0]      cmd_color,
    input  logic                    cmd_swap,
    output logic [31:0]             info,
    output logic                    info_valid,
    input  logic                    info_ready,
    output logic                    busy
);

    localparam int CW = SCREEN_WIDTH - 1;
    localparam logic [31:0] SWAP_WORD = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, RUN, SWAP} state_t;

    state_t            state_q, state_n;
    logic [CW-1:0]     x0_q, x0_n;
    logic [CW-1:0]     w_q, w_n;
    logic [COLOR_W-1:0] color_q, color_n;
    logic              swap_q, swap_n;
    logic [CW-1:0]     cx_q, cx_n;
    logic [CW-1:0]     cy_q, cy_n;
    logic [CW-1:0]     col_q, col_n;   // pixels left in current row, incl. current
    logic [CW-1:0]     row_q, row_n;   // rows left, incl. current
    logic [31:0]       info_n;
    logic              vld_n;
    logic              load_pix;       // (cx_n, cy_n) is a new pixel to present
    logic              pix_ok;         // that pixel produces a word

    function automatic logic [31:0] pix_word(input logic [CW-1:0] x,
                                             input logic [CW-1:0] y,
                                             input logic [COLOR_W-1:0] c);
        logic [31:0] w;
        w = '0;
        w[7+2*SCREEN_WIDTH:8+SCREEN_WIDTH] = {x, 1'b0};
        w[7+SCREEN_WIDTH:8]                = {y, 1'b0};
        w[COLOR_W-1:0]                     = c;
        return w;
    endfunction

`ifdef VGA_RECT_CLIP_EN
    function automatic logic in_win(input logic [CW-1:0] x, input logic [CW-1:0] y);
        int xi;
        int yi;
        xi = int'(x);
        yi = int'(y);
        return (xi >= 76) && (xi <= 563) && (yi >= 100) && (yi <= 379);
    endfunction
`endif

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            w_q        <= '0;
            color_q    <= '0;
            swap_q     <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            info       <= '0;
            info_valid <= 1'b0;
        end else begin
            state_q    <= state_n;
            x0_q       <= x0_n;
            w_q        <= w_n;
            color_q    <= color_n;
            swap_q     <= swap_n;
            cx_q       <= cx_n;
            cy_q       <= cy_n;
            col_q      <= col_n;
            row_q      <= row_n;
            info       <= info_n;
            info_valid <= vld_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        x0_n     = x0_q;
        w_n      = w_q;
        color_n  = color_q;
        swap_n   = swap_q;
        cx_n     = cx_q;
        cy_n     = cy_q;
        col_n    = col_q;
        row_n    = row_q;
        info_n   = info;
        vld_n    = info_valid;
        load_pix = 1'b0;
        pix_ok   = 1'b1;

        case (state_q)
            IDLE: begin
                vld_n = 1'b0;
                if (cmd_valid) begin
                    x0_n    = cmd_x0;
                    w_n     = cmd_w;
                    color_n = cmd_color;
                    swap_n  = cmd_swap;
                    cx_n    = cmd_x0;
                    cy_n    = cmd_y0;
                    col_n   = cmd_w;
                    row_n   = cmd_h;
                    if (cmd_w == '0 || cmd_h == '0) begin
                        if (cmd_swap) begin
                            state_n = SWAP;
                            info_n  = SWAP_WORD;
                            vld_n   = 1'b1;
                        end
                    end else begin
                        state_n  = RUN;
                        load_pix = 1'b1;
                    end
                end
            end
            RUN: begin
                // A skipped (clipped) pixel has info_valid low and advances
                // without waiting for the sink.
                if (!info_valid || info_ready) begin
                    if (col_q == CW'(1) && row_q == CW'(1)) begin
                        if (swap_q) begin
                            state_n = SWAP;
                            info_n  = SWAP_WORD;
                            vld_n   = 1'b1;
                        end else begin
                            state_n = IDLE;
                            vld_n   = 1'b0;
                        end
                    end else if (col_q == CW'(1)) begin
                        cx_n     = x0_q;
                        cy_n     = cy_q + 1'b1;
                        col_n    = w_q;
                        row_n    = row_q - 1'b1;
                        load_pix = 1'b1;
                    end else begin
                        cx_n     = cx_q + 1'b1;
                        col_n    = col_q - 1'b1;
                        load_pix = 1'b1;
                    end
                end
            end
            SWAP: begin
                if (info_ready) begin
                    state_n = IDLE;
                    vld_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                vld_n   = 1'b0;
            end
        endcase

        if (load_pix) begin
`ifdef VGA_RECT_CLIP_EN
            pix_ok = in_win(cx_n, cy_n);
`else
            pix_ok = 1'b1;
`endif
            vld_n = pix_ok;
            if (pix_ok)
                info_n = pix_word(cx_n, cy_n, color_n);
        end
    end

endmodule
